// File: rtl/uart_arb_pkg.sv
// Shared FSM encoding and default sizing for the UART transmit arbiter.
// No logic; imported by the arbiter top and its interface.
package uart_arb_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    localparam int NUM_REQ_DEF        = 4;
    localparam int TIMEOUT_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        LAUNCH    = ST_LAUNCH,
        WAIT_DONE = ST_WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester + transmitter signal bundle; master = arbiter, slave = requesters and UART.
// gnt/tx_start are single-cycle pulses; tx_busy holds off launch.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = uart_arb_pkg::NUM_REQ_DEF
);
    localparam int OW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 tx_done;
    logic [OW-1:0]        owner;
    logic                 busy;
    logic                 err_timeout;

    modport master (
        input  req, req_data, tx_busy, tx_done,
        output gnt, tx_start, tx_data, owner, busy, err_timeout
    );

    modport slave (
        output req, req_data, tx_busy, tx_done,
        input  gnt, tx_start, tx_data, owner, busy, err_timeout
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Round-robin winner: first requesting index after last_owner, wrapping to 0.
// Purely combinational; valid is low when no request bit is set.
module uart_rr_pick #(
    parameter  int NUM_REQ = uart_arb_pkg::NUM_REQ_DEF,
    localparam int OW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OW-1:0]      last_owner,
    output logic               valid,
    output logic [OW-1:0]      winner
);

    int   idx;
    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_owner) + k) % NUM_REQ;
            if (!found && req[OW'(idx)]) begin
                found  = 1'b1;
                winner = OW'(idx);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters; gnt 1 cycle after req, tx_start once tx_busy is low.
// Optional WAIT_DONE watchdog (TIMEOUT_CYCLES, err_timeout) compiled in with UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ = uart_arb_pkg::NUM_REQ_DEF
`ifdef UART_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = uart_arb_pkg::TIMEOUT_CYCLES_DEF
`endif
) (
    input logic               clk_uart,
    input logic               rst,
    uart_tx_arbiter_if.master bus
);
    import uart_arb_pkg::*;

    localparam int OW = $clog2(NUM_REQ);

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
    logic               tx_start_q, tx_start_nxt;
    logic [7:0]         tx_data_q, tx_data_nxt;
    logic [OW-1:0]      owner_q, owner_nxt;
    logic [OW-1:0]      last_owner, last_owner_nxt;
    logic               busy_q, busy_nxt;
    logic               pick_vld;
    logic [OW-1:0]      pick_idx;
    logic               timeout_hit;

    uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (bus.req),
        .last_owner (last_owner),
        .valid      (pick_vld),
        .winner     (pick_idx)
    );

    always_ff @(posedge clk_uart or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            gnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            owner_q    <= '0;
            last_owner <= OW'(NUM_REQ - 1);
            busy_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            gnt_q      <= gnt_nxt;
            tx_start_q <= tx_start_nxt;
            tx_data_q  <= tx_data_nxt;
            owner_q    <= owner_nxt;
            last_owner <= last_owner_nxt;
            busy_q     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        gnt_nxt        = '0;
        tx_start_nxt   = 1'b0;
        tx_data_nxt    = tx_data_q;
        owner_nxt      = owner_q;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt         = LAUNCH;
                    gnt_nxt[pick_idx] = 1'b1;
                    owner_nxt         = pick_idx;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (pick_idx == OW'(i)) begin
                            tx_data_nxt = bus.req_data[8*i +: 8];
                        end
                    end
                end
            end
            LAUNCH: begin
                if (!bus.tx_busy) begin
                    state_nxt    = WAIT_DONE;
                    tx_start_nxt = 1'b1;
                end
            end
            WAIT_DONE: begin
                // tx_done and timeout both release the pointer to owner+1
                if (bus.tx_done || timeout_hit) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = owner_q;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] to_cnt;
    logic          err_q;

    // to_cnt counts completed WAIT_DONE cycles, so this fires on the TIMEOUT_CYCLES-th edge
    assign timeout_hit = (state == WAIT_DONE) && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_uart or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= (state == WAIT_DONE) ? to_cnt + CW'(1) : '0;
            err_q  <= timeout_hit && !bus.tx_done;
        end
    end

    assign bus.err_timeout = err_q;
`else
    assign timeout_hit     = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.gnt      = gnt_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.owner    = owner_q;
    assign bus.busy     = busy_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, 16, max clk_uart cycles in WAIT_DONE before abort (only with UART_ARB_TIMEOUT_EN).
REQ-003 Port clk_uart  in  1  single clock; all state changes on rising edge.
REQ-004 Port rst  in  1  asynchronous, active-low reset.
REQ-005 Port req  in  NUM_REQ  level request per requester; bit i = requester i has a byte pending.
REQ-006 Port req_data  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
REQ-007 Port gnt  out  NUM_REQ  one-hot, one-cycle pulse acknowledging the byte taken from requester i.
REQ-008 Port tx_start  out  1  one-cycle pulse commanding the transmitter to send tx_data.
REQ-009 Port tx_data  out  8  latched byte, stable from grant until frame done.
REQ-010 Port tx_busy  in  1  transmitter is mid-frame.
REQ-011 Port tx_done  in  1  one-cycle pulse at end of stop bit.
REQ-012 Port owner  out  clog2(NUM_REQ)  index of current or last granted requester.
REQ-013 Port busy  out  1  high in any state other than IDLE.
REQ-014 Port err_timeout  out  1  one-cycle pulse on frame abort.

Function
REQ-015 The FSM SHALL have states IDLE, LAUNCH and WAIT_DONE; all outputs SHALL be registered.
REQ-016 IDLE: when any req bit is sampled high, the block SHALL select winner w by round robin, starting at (last_owner+1) mod NUM_REQ.
REQ-017 On that same edge, the block SHALL latch tx_data=req_data[w], set owner=w, pulse gnt[w] in the following cycle, and go to LAUNCH.
REQ-018 LAUNCH: if tx_busy=0, the block SHALL pulse tx_start for one cycle and go to WAIT_DONE; if tx_busy=1, it SHALL hold in LAUNCH with tx_start=0.
REQ-019 WAIT_DONE: on tx_done=1 the block SHALL set last_owner=owner and return to IDLE; a new grant SHALL be possible on the next edge.
REQ-020 Minimum latency from req sampled to tx_start high SHALL be 2 cycles; minimum spacing between grants SHALL be 3 cycles plus frame time.
REQ-021 A requester whose req stays high after gnt SHALL be treated as presenting a new byte.
REQ-022 A req deasserted while another requester owns the transmitter SHALL be ignored with no side effect.
REQ-023 A tx_done pulse in IDLE or LAUNCH SHALL be ignored.
REQ-024 With a single active requester, that requester SHALL be granted every opportunity; pointer wrap from NUM_REQ-1 to 0 SHALL be seamless.

Reset
REQ-025 While rst=0: state=IDLE, gnt=0, tx_start=0, tx_data=8'h00, owner=0, busy=0, err_timeout=0, last_owner=NUM_REQ-1 (requester 0 wins first).
REQ-026 Reset asserted mid-frame SHALL abandon the frame immediately, with no gnt, tx_start or err_timeout pulse generated.

Configuration
REQ-027 With UART_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT_DONE and increment each cycle.
REQ-028 With UART_ARB_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without tx_done SHALL pulse err_timeout, set last_owner=owner and return to IDLE.
REQ-029 With UART_ARB_TIMEOUT_EN defined, tx_done arriving in the same cycle as timeout SHALL win, with no err_timeout pulse.
REQ-030 With UART_ARB_TIMEOUT_EN undefined, no counter SHALL exist, WAIT_DONE SHALL wait indefinitely, and err_timeout SHALL be tied to 0.

Structure
REQ-031 Package uart_arb_pkg SHALL hold the state encoding localparams (IDLE, LAUNCH, WAIT_DONE) and the NUM_REQ and TIMEOUT_CYCLES defaults.
REQ-032 The round-robin selection SHALL be a combinational sub-module uart_rr_pick (inputs req, last_owner; outputs valid, winner index).

Verification
REQ-033 Reset, then req=4'b0001, req_data byte0=8'hA5 -> gnt=4'b0001 after 1 cycle, tx_data=8'hA5, tx_start after 2 cycles; tx_done -> busy=0.
REQ-034 req=4'b1111 held, bytes 8'h10/8'h21/8'h32/8'h43, tx_done after each frame -> grant order 0,1,2,3,0 and tx_data sequence 8'h10,8'h21,8'h32,8'h43,8'h10.
REQ-035 Grant while tx_busy=1 for 5 cycles -> block holds in LAUNCH, tx_start pulses once, in the cycle after tx_busy falls.
REQ-036 With UART_ARB_TIMEOUT_EN, no tx_done -> err_timeout pulse exactly 16 cycles after WAIT_DONE entry, and the next grant goes to owner+1; tx_done at cycle 16 -> no err_timeout.
REQ-037 rst=0 in WAIT_DONE with owner=2 -> all outputs at reset values; after release, req=4'b0100 -> gnt=4'b0100 (requester 2 granted, pointer reset to start at requester 0).
